// File: rtl/vector_checker.sv
// Table-driven stimulus/check engine for combinational kernels: applies each stored
// vector, waits SETTLE cycles, compares the response. Optional macro VECTOR_CHECKER_CONTINUE_EN.
//
// state  | meaning
// IDLE   | waiting for start, table writable
// APPLY  | drive stim[idx] onto dut_i, load settle timer
// SETTLE | settle timer running down
// CHECK  | compare dut_o against exp[idx]
// GAP    | inter-vector idle timer running down
// DONE   | run ended with no mismatch
// FAIL   | run ended with at least one mismatch
module vector_checker #(
  parameter int IN_W    = 2,
  parameter int OUT_W   = 1,
  parameter int NUM_VEC = 4,
  parameter int AW      = 2,
  parameter int SETTLE  = 1,
  parameter int GAP     = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [IN_W-1:0]  wr_in,
  input  logic [OUT_W-1:0] wr_exp,
  input  logic             start,
  output logic [IN_W-1:0]  dut_i,
  input  logic [OUT_W-1:0] dut_o,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [AW-1:0]    fail_idx,
  output logic [OUT_W-1:0] got,
  output logic [OUT_W-1:0] expected,
  output logic [AW:0]      err_count
);

  localparam int DEPTH = 1 << AW;
  localparam int MAXV  = (SETTLE > GAP) ? SETTLE : GAP;
  localparam int CW    = (MAXV > 1) ? $clog2(MAXV) : 1;

  localparam logic [AW:0]    NUM_VEC_W = (AW+1)'(NUM_VEC);
  localparam logic [AW-1:0]  LAST_IDX  = AW'(NUM_VEC - 1);
  localparam logic [CW-1:0]  SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [CW-1:0]  GAP_LD    = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_t;

  state_t           r_state;
  logic [IN_W-1:0]  r_stim [DEPTH];
  logic [OUT_W-1:0] r_exp  [DEPTH];
  logic [AW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;
  logic [IN_W-1:0]  r_dut_i;
  logic             r_busy;
  logic             r_done;
  logic             r_fail;
  logic [AW-1:0]    r_fail_idx;
  logic [OUT_W-1:0] r_got;
  logic [OUT_W-1:0] r_expected;
  logic [AW:0]      r_err;

  logic             w_wr_ok;
  logic [OUT_W-1:0] w_cur_exp;
  logic             w_mismatch;
  logic             w_err_sat;
  logic [AW:0]      w_err_next;
  logic             w_last;

  // Table is frozen while a run is active; out-of-range addresses are dropped.
  assign w_wr_ok    = wr_en & ~r_busy & ({1'b0, wr_addr} < NUM_VEC_W);
  assign w_cur_exp  = r_exp[r_idx];
  assign w_mismatch = (dut_o != w_cur_exp);
  assign w_err_sat  = &r_err;
  assign w_err_next = (w_mismatch && !w_err_sat) ? r_err + 1'b1 : r_err;
  assign w_last     = (r_idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (w_wr_ok) begin
      r_stim[wr_addr] <= wr_in;
      r_exp[wr_addr]  <= wr_exp;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_dut_i    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_fail_idx <= '0;
      r_got      <= '0;
      r_expected <= '0;
      r_err      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_err      <= '0;
            r_fail_idx <= '0;
            r_got      <= '0;
            r_expected <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_APPLY;
          end
        end

        S_APPLY: begin
          r_dut_i <= r_stim[r_idx];
          r_cnt   <= SETTLE_LD;
          r_state <= S_SETTLE;
        end

        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && (r_err == '0)) begin
            r_fail_idx <= r_idx;
            r_got      <= dut_o;
            r_expected <= w_cur_exp;
          end
`ifdef VECTOR_CHECKER_CONTINUE_EN
          if (w_last) begin
            r_busy <= 1'b0;
            if (w_err_next == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_fail  <= 1'b1;
              r_state <= S_FAIL;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
            if (GAP == 0) begin
              r_state <= S_APPLY;
            end else begin
              r_cnt   <= GAP_LD;
              r_state <= S_GAP;
            end
          end
`else
          if (w_mismatch) begin
            r_busy  <= 1'b0;
            r_fail  <= 1'b1;
            r_state <= S_FAIL;
          end else if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
            if (GAP == 0) begin
              r_state <= S_APPLY;
            end else begin
              r_cnt   <= GAP_LD;
              r_state <= S_GAP;
            end
          end
`endif
        end

        S_GAP: begin
          if (r_cnt == '0) begin
            r_state <= S_APPLY;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dut_i     = r_dut_i;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fail      = r_fail;
  assign fail_idx  = r_fail_idx;
  assign got       = r_got;
  assign expected  = r_expected;
  assign err_count = r_err;

endmodule

// File: doc/vector_checker.md
Name: vector_checker

Overview:
Synchronous stimulus-and-check engine that is the hardware counterpart of the generated simulation testbenches. It holds a table of (input, expected output) vectors, drives each input onto a combinational DUT kernel such as the 2-bit AND gate, waits a settle interval, then samples the DUT output and compares it with the expected value. It reports pass or fail, the failing vector index, and the got/expected values. It sits in on-chip self-test wrappers around generated kernels.

Parameters:
IN_W, 2, DUT input width in bits
OUT_W, 1, DUT output width in bits
NUM_VEC, 4, vector table depth (>=1)
AW, 2, table address width; 2**AW >= NUM_VEC
SETTLE, 1, clock cycles between driving dut_i and sampling dut_o (>=1)
GAP, 2, idle cycles after a check before the next vector is applied (>=0)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
wr_en  in  1  table write strobe; ignored while busy=1
wr_addr  in  AW  table write address; writes with wr_addr>=NUM_VEC are dropped
wr_in  in  IN_W  stimulus value to store
wr_exp  in  OUT_W  expected output to store
start  in  1  single-cycle run request; honoured only in IDLE, DONE or FAIL
dut_i  out  IN_W  stimulus driven to the DUT
dut_o  in  OUT_W  DUT response
busy  out  1  run in progress
done  out  1  run completed with no mismatches (sticky until next start or reset)
fail  out  1  mismatch detected (sticky until next start or reset)
fail_idx  out  AW  index of the first mismatching vector
got  out  OUT_W  dut_o captured at the first mismatch
expected  out  OUT_W  expected value at the first mismatch
err_count  out  AW+1  number of mismatching vectors in the current run (saturating)

Behaviour:
- Reset (asynchronous, active-high) sets state=IDLE, dut_i=0, busy=0, done=0, fail=0, fail_idx=0, got=0, expected=0, err_count=0, idx=0. Table contents are not reset.
- Table: NUM_VEC entries of {IN_W stim, OUT_W exp}, written synchronously when wr_en=1 and busy=0.
- FSM states are IDLE, APPLY, SETTLE, CHECK, GAP, DONE and FAIL.
- IDLE/DONE/FAIL with start=1: clear done, fail, err_count, fail_idx, got and expected; set idx=0 and busy=1; go to APPLY.
- APPLY (1 cycle): register dut_i <= stim[idx]; load the settle counter with SETTLE-1; go to SETTLE. dut_i changes only on this edge.
- SETTLE: decrement the counter. When the counter is 0, go to CHECK. Sampling happens SETTLE cycles after dut_i updates.
- CHECK (1 cycle): compare dut_o with exp[idx], using exact equality over all OUT_W bits.
  - On mismatch with err_count=0, capture fail_idx=idx, got=dut_o and expected=exp[idx].
  - On any mismatch, err_count increments, saturating at 2**(AW+1)-1.
  - Stop on mismatch (no macro): go to FAIL, with busy=0 and fail=1.
  - Otherwise, if idx==NUM_VEC-1, finish: if err_count (including this check) is 0, go to DONE with done=1; else go to FAIL with fail=1. busy=0 in both cases.
  - Otherwise idx++ and go to GAP. If GAP=0, go directly to APPLY.
- GAP: count GAP cycles, then go to APPLY.
- Per-vector cost is 1+SETTLE+1+GAP cycles. Total run latency from start to done/fail is NUM_VEC*(2+SETTLE+GAP)-GAP cycles.
- start while busy is ignored. wr_en while busy is ignored, so the table is stable during a run.
- dut_i holds the last applied vector after the run ends.
- Reset mid-run aborts immediately into the reset state; no partial result survives.
- NUM_VEC=1: the single vector runs, then DONE or FAIL; idx never increments.
- done and fail are never both 1.

Optional Feature:
Macro VECTOR_CHECKER_CONTINUE_EN.
- Defined: a mismatch does not stop the run. All vectors are checked. fail_idx/got/expected keep the first mismatch; err_count counts every mismatch. The final state is FAIL if err_count>0, else DONE.
- Undefined: the run stops at the first mismatch (FAIL), so err_count is at most 1.

Test Plan:
- AND-gate truth table: load {01,0},{10,0},{11,1},{00,0}, DUT=and, SETTLE=1, GAP=2, pulse start -> dut_i steps 01,10,11,00; done=1, fail=0 and err_count=0 after 4*5-2=18 cycles.
- Wrong expectation: entry 2 set to {11,0} -> without the macro, fail=1, fail_idx=2, got=1, expected=0, err_count=1, and dut_i stays 11. With the macro, the run finishes at entry 3 with fail=1 and err_count=1.
- Two bad entries (1 and 3) with the macro -> fail_idx=1, err_count=2; without the macro, the run stops at idx 1.
- Control ignored while busy: start pulse and wr_en to addr 0 mid-run -> the run is unaffected, table entry 0 is unchanged and the total latency is still 18.
- Reset assertion during SETTLE of vector 1 -> outputs immediately 0 and state IDLE; a new start reruns from vector 0 and reaches done.
- Out-of-range write: NUM_VEC=3, AW=2, write to addr 3 -> dropped; the run checks exactly 3 vectors.
